// File: rtl/fetch_sequencer.sv
// Instruction-fetch controller for the dual-bank Program_Rom: PC/ROM select generation, small queue, 0-2 issue per cycle.
// Optional macro FETCH_BYPASS_EN: when the queue is empty, ROM data is driven straight to the decoder in the fetch cycle.
module fetch_sequencer #(
  parameter int ADDR_W = 14,
  parameter int QDEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic              branch_valid,
  input  logic [ADDR_W:0]   branch_target,
  input  logic [1:0]        dec_ready,
  output logic [1:0]        ir_valid,
  output logic [15:0]       ir0,
  output logic [15:0]       ir1,
  output logic [ADDR_W:0]   pc_out,
  output logic [ADDR_W-1:0] rom_addr,
  output logic              rom_pc_1,
  output logic              rom_sel_mem_1,
  output logic [1:0]        rom_sel_mem_0,
  input  logic [15:0]       rom_ir_0,
  input  logic [15:0]       rom_ir_1
);

  localparam int PW = $clog2(QDEPTH);
  localparam int CW = $clog2(QDEPTH + 1);
  localparam logic [CW-1:0]   DEPTH_C = CW'(QDEPTH);
  localparam logic [ADDR_W:0] PC_ONE  = 1;

  typedef struct packed {
    logic [15:0]     instr;
    logic [ADDR_W:0] pc;
  } entry_t;

  typedef enum logic [1:0] {BOOT = 2'd0, RUN = 2'd1, FULL = 2'd2} state_t;

  state_t          state, state_nxt;
  logic [ADDR_W:0] fetch_pc;
  logic [CW-1:0]   count, cnt_nxt, free;
  logic [PW-1:0]   head, tail, head_p1, tail_p1;
  entry_t          q [QDEPTH];
  logic [1:0]      dec_n, n_pop, n_wr, pc_adv;
  logic            active, fetch_ok, bypass;
  entry_t          ent_a, ent_b, wr0, wr1;

  // Pointer increment by 0..2 with wrap for non-power-of-two depths
  function automatic logic [PW-1:0] ptr_add(input logic [PW-1:0] p, input logic [1:0] n);
    int s;
    s = int'(p) + int'(n);
    if (s >= QDEPTH) s = s - QDEPTH;
    return PW'(s);
  endfunction

  assign dec_n    = (dec_ready == 2'd3) ? 2'd2 : dec_ready;
  assign active   = !rst && !branch_valid && !stall;
  assign fetch_ok = active && (state == RUN);
  assign free     = DEPTH_C - count;
  assign head_p1  = ptr_add(head, 2'd1);
  assign tail_p1  = ptr_add(tail, 2'd1);
  assign ent_a    = '{instr: rom_ir_0, pc: fetch_pc};
  assign ent_b    = '{instr: rom_ir_1, pc: fetch_pc + PC_ONE};

`ifdef FETCH_BYPASS_EN
  assign bypass = fetch_ok && (count == '0);
`else
  assign bypass = 1'b0;
`endif

  // Fetch sizing uses the registered count so dec_ready never reaches the write path
  always_comb begin
    n_pop  = '0;
    n_wr   = '0;
    pc_adv = '0;
    wr0    = ent_a;
    wr1    = ent_b;
    if (bypass) begin
      pc_adv = 2'd2;
      n_wr   = 2'd2 - dec_n;
      if (dec_n == 2'd1) wr0 = ent_b;
    end else if (fetch_ok) begin
      if (free >= CW'(2)) begin
        n_wr   = 2'd2;
        pc_adv = 2'd2;
      end else if (free == CW'(1)) begin
        n_wr   = 2'd1;
        pc_adv = 2'd1;
      end
    end
    if (active && !bypass)
      n_pop = (CW'(dec_n) > count) ? count[1:0] : dec_n;
  end

  assign cnt_nxt = count - CW'(n_pop) + CW'(n_wr);

  always_ff @(posedge clk) begin
    if (rst) state <= BOOT;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (branch_valid) state_nxt = RUN;
    else begin
      case (state)
        BOOT:    state_nxt = RUN;
        RUN:     if (cnt_nxt == DEPTH_C) state_nxt = FULL;
        FULL:    if (cnt_nxt != DEPTH_C) state_nxt = RUN;
        default: state_nxt = BOOT;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc <= '0;
      count    <= '0;
      head     <= '0;
      tail     <= '0;
    end else if (branch_valid) begin
      fetch_pc <= branch_target;
      count    <= '0;
      head     <= '0;
      tail     <= '0;
    end else begin
      fetch_pc <= fetch_pc + (ADDR_W+1)'(pc_adv);
      count    <= cnt_nxt;
      head     <= ptr_add(head, n_pop);
      tail     <= ptr_add(tail, n_wr);
    end
  end

  // Queue storage needs no reset: count gates every read
  always_ff @(posedge clk) begin
    if (n_wr != 2'd0) q[tail]    <= wr0;
    if (n_wr == 2'd2) q[tail_p1] <= wr1;
  end

  always_comb begin
    rom_addr      = fetch_pc[ADDR_W:1];
    rom_pc_1      = fetch_pc[0];
    rom_sel_mem_0 = fetch_pc[0] ? 2'd2 : 2'd0;
    rom_sel_mem_1 = !fetch_pc[0];
    ir_valid      = '0;
    ir0           = '0;
    ir1           = '0;
    pc_out        = '0;
    if (bypass) begin
      ir_valid = 2'd2;
      ir0      = rom_ir_0;
      ir1      = rom_ir_1;
      pc_out   = fetch_pc;
    end else begin
      ir_valid = (count >= CW'(2)) ? 2'd2 : count[1:0];
      if (count >= CW'(1)) begin
        ir0    = q[head].instr;
        pc_out = q[head].pc;
      end
      if (count >= CW'(2)) ir1 = q[head_p1].instr;
    end
  end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Scoreboard bench for fetch_sequencer: a queue-based reference model predicts each cycle's outputs, a monitor compares.
module tb_fetch_sequencer;
  localparam int AW = 14;
  localparam int QD = 4;

  logic          clk = 1'b0;
  logic          rst, stall, branch_valid;
  logic [AW:0]   branch_target;
  logic [1:0]    dec_ready, ir_valid, rom_sel_mem_0;
  logic [15:0]   ir0, ir1, rom_ir_0, rom_ir_1;
  logic [AW:0]   pc_out;
  logic [AW-1:0] rom_addr;
  logic          rom_pc_1, rom_sel_mem_1;

  always #5 clk = ~clk;

  fetch_sequencer #(.ADDR_W(AW), .QDEPTH(QD)) dut (
    .clk(clk), .rst(rst), .stall(stall), .branch_valid(branch_valid),
    .branch_target(branch_target), .dec_ready(dec_ready),
    .ir_valid(ir_valid), .ir0(ir0), .ir1(ir1), .pc_out(pc_out),
    .rom_addr(rom_addr), .rom_pc_1(rom_pc_1), .rom_sel_mem_1(rom_sel_mem_1),
    .rom_sel_mem_0(rom_sel_mem_0), .rom_ir_0(rom_ir_0), .rom_ir_1(rom_ir_1)
  );

  // Program image: 64 words, everything above reads as 0x0000
  logic [15:0] prog [64];

  function automatic logic [15:0] rom_word(input logic [AW:0] a);
    if (a < 15'd64) return prog[a[5:0]];
    return 16'h0000;
  endfunction

  assign rom_ir_0 = rom_word({rom_addr, rom_pc_1});
  assign rom_ir_1 = rom_word({rom_addr, rom_pc_1} + 15'd1);

  typedef struct {
    logic [15:0] ins;
    logic [AW:0] pc;
  } ent_t;

  typedef struct {
    logic [1:0]    v;
    logic [15:0]   i0, i1;
    logic [AW:0]   pc;
    logic [AW-1:0] ra;
    logic          p1, s1;
    logic [1:0]    s0;
  } exp_t;

  ent_t        mq[$];
  exp_t        sb[$];
  logic [AW:0] mpc;
  bit          mboot;
  int          checks = 0;
  int          errors = 0;

  function automatic bit bypass_on();
`ifdef FETCH_BYPASS_EN
    return 1'b1;
`else
    return 1'b0;
`endif
  endfunction

  // Apply one cycle of inputs, predict that cycle's outputs, then advance the model across the edge
  task automatic step(input bit r, input bit s, input bit b, input logic [AW:0] t, input logic [1:0] d);
    exp_t e;
    bit   bp;
    int   dn, fr, w, sz;
    ent_t en;
    rst = r; stall = s; branch_valid = b; branch_target = t; dec_ready = d;
    sz = mq.size();
    bp = bypass_on() && !r && !b && !s && !mboot && (sz == 0);
    e.ra = mpc[AW:1];
    e.p1 = mpc[0];
    e.s0 = mpc[0] ? 2'd2 : 2'd0;
    e.s1 = !mpc[0];
    if (bp) begin
      e.v = 2'd2; e.i0 = rom_word(mpc); e.i1 = rom_word(mpc + 15'd1); e.pc = mpc;
    end else begin
      e.v  = (sz >= 2) ? 2'd2 : 2'(sz);
      e.i0 = (sz > 0) ? mq[0].ins : 16'h0;
      e.i1 = (sz > 1) ? mq[1].ins : 16'h0;
      e.pc = (sz > 0) ? mq[0].pc : '0;
    end
    sb.push_back(e);
    @(posedge clk);
    dn = (d == 2'd3) ? 2 : int'(d);
    if (r) begin
      mq.delete(); mpc = '0; mboot = 1'b1;
    end else if (b) begin
      mq.delete(); mpc = t; mboot = 1'b0;
    end else if (s || mboot) begin
      mboot = 1'b0;
    end else if (bp) begin
      for (int k = dn; k < 2; k++) begin
        en.pc = mpc + 15'(k); en.ins = rom_word(en.pc); mq.push_back(en);
      end
      mpc = mpc + 15'd2;
    end else begin
      fr = QD - sz;
      w  = (fr > 2) ? 2 : fr;
      for (int k = 0; k < dn && mq.size() > 0; k++) void'(mq.pop_front());
      for (int k = 0; k < w; k++) begin
        en.pc = mpc + 15'(k); en.ins = rom_word(en.pc); mq.push_back(en);
      end
      mpc = mpc + 15'(w);
    end
    #1;
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        checks++;
        if (ir_valid !== e.v || ir0 !== e.i0 || ir1 !== e.i1 || pc_out !== e.pc) begin
          errors++;
          $display("FAIL out t=%0t got v=%0d ir0=%h ir1=%h pc=%h want v=%0d ir0=%h ir1=%h pc=%h",
                   $time, ir_valid, ir0, ir1, pc_out, e.v, e.i0, e.i1, e.pc);
        end
        checks++;
        if (rom_addr !== e.ra || rom_pc_1 !== e.p1 || rom_sel_mem_0 !== e.s0 || rom_sel_mem_1 !== e.s1) begin
          errors++;
          $display("FAIL rom t=%0t got addr=%h pc1=%b s0=%0d s1=%b want addr=%h pc1=%b s0=%0d s1=%b",
                   $time, rom_addr, rom_pc_1, rom_sel_mem_0, rom_sel_mem_1, e.ra, e.p1, e.s0, e.s1);
        end
      end
    end
  end

  initial begin : stim
    logic [AW:0] t;
    prog[0] = 16'h210A; prog[1] = 16'h220C; prog[2] = 16'h230E;
    prog[3] = 16'hB40E; prog[4] = 16'hBC70;
    for (int k = 5; k < 64; k++) prog[k] = 16'($urandom);
    rst = 1'b1; stall = 1'b0; branch_valid = 1'b0; branch_target = '0; dec_ready = 2'd0;
    @(posedge clk);
    mq.delete(); mpc = '0; mboot = 1'b1;
    #1;
    step(1, 0, 0, 0, 0);
    repeat (4) step(0, 0, 0, 0, 0);
    repeat (4) step(0, 0, 0, 0, 2);
    step(0, 0, 1, 15'd1, 0);
    repeat (3) step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0);
    repeat (3) step(0, 0, 0, 0, 1);
    repeat (3) step(0, 1, 0, 0, 2);
    step(0, 1, 1, 15'd3, 2);
    repeat (3) step(0, 0, 0, 0, 2);
    step(0, 0, 1, 15'd20, 1);
    step(1, 0, 0, 0, 0);
    repeat (3) step(0, 0, 0, 0, 2);
    step(0, 0, 1, 15'd3, 0);
    repeat (2) step(0, 0, 0, 0, 2);
    step(0, 0, 1, 15'h7FFF, 0);
    repeat (3) step(0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 3);
    repeat (800) begin
      t = ($urandom_range(0, 3) == 0) ? 15'(32768 - $urandom_range(1, 4)) : 15'($urandom_range(0, 70));
      step($urandom_range(0, 99) == 0, $urandom_range(0, 5) == 0, $urandom_range(0, 11) == 0,
           t, 2'($urandom_range(0, 3)));
    end
    repeat (3) @(negedge clk);
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain pending=%0d want 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
- Instruction-fetch controller for the dual-bank Program_Rom (bank 0 holds even halfwords, bank 1 holds odd halfwords).
- Holds the fetch PC and drives the ROM address, odd-offset and bank-mux selects, so every cycle presents two consecutive instructions from any halfword PC, even or odd.
- Buffers fetched instructions in a small queue and hands 0–2 per cycle to the decoder.
- Handles branch redirect with a queue flush, and pipeline stall.

Parameters:
- ADDR_W, 14, ROM row address width; the fetch PC is ADDR_W+1 bits, in halfwords.
- QDEPTH, 4, instruction queue depth in entries; must be ≥2.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- stall  in  1  freeze pop and fetch
- branch_valid  in  1  redirect request
- branch_target  in  ADDR_W+1  halfword target address
- dec_ready  in  2  number of instructions the decoder takes this cycle (0..2; value 3 treated as 2)
- ir_valid  out  2  number of valid instructions on ir0/ir1 (0..2)
- ir0  out  16  oldest instruction
- ir1  out  16  next instruction
- pc_out  out  ADDR_W+1  halfword address of ir0
- rom_addr  out  ADDR_W  drives Rom_addr_in
- rom_pc_1  out  1  drives pc_1
- rom_sel_mem_1  out  1  drives sel_mem_1
- rom_sel_mem_0  out  2  drives sel_mem_0
- rom_ir_0  in  16  from IR_0
- rom_ir_1  in  16  from IR_1

Behaviour:
- ROM mapping (combinational from fetch_pc):
  - rom_addr = fetch_pc[ADDR_W:1]; rom_pc_1 = fetch_pc[0].
  - Even PC: sel_mem_0 = 0, sel_mem_1 = 1.
  - Odd PC: sel_mem_0 = 2, sel_mem_1 = 0.
  - sel_mem_0 = 1 is never driven.
  - rom_ir_0 is the instruction at fetch_pc; rom_ir_1 is the one at fetch_pc+1. The ROM is combinational, so capture happens at the same clock edge.
- States:
  - BOOT: first cycle after reset; no fetch. Go to RUN.
  - RUN: fetch into the queue.
  - FULL: entered when count == QDEPTH; no fetch. Return to RUN when count < QDEPTH.
- Fetch amount uses registered count (pre-pop, no combinational path from dec_ready):
  - free ≥ 2: write both instructions, fetch_pc += 2.
  - free == 1: write rom_ir_0 only, fetch_pc += 1.
  - free == 0: no write.
- Pop: pops min(dec_ready, count) from the head each cycle. Outputs:
  - ir_valid = min(count, 2).
  - ir0/ir1 come from the head entries; slots that are not valid read as 0.
  - pc_out is the address of the head entry.
- Each queue entry stores the instruction and its halfword PC.
- stall = 1: no pop, no fetch; queue and fetch_pc hold. Outputs stay stable.
- Branch (branch_valid = 1) has priority over stall, pop and fetch:
  - Queue emptied; fetch_pc <= branch_target; state <= RUN.
  - Nothing fetched that cycle; ir_valid = 0 from the next cycle.
  - The target is fetched in the following cycle.
  - Latency: branch in cycle t, ir_valid ≠ 0 in cycle t+2.
- fetch_pc wraps modulo 2^(ADDR_W+1). Out-of-range ROM data (0x0000) is queued normally.
- Reset (synchronous; applies at any point, including mid-fetch or mid-branch) sets:
  - state BOOT, fetch_pc 0, count 0, pointers 0.
  - ir_valid 0, ir0 0, ir1 0, pc_out 0.
  - rom_addr 0, rom_pc_1 0, rom_sel_mem_1 1, rom_sel_mem_0 0.
- Reset-to-first-valid: rst released in cycle r, BOOT in r, fetch in r+1, ir_valid = 2 in r+2.

Optional Feature:
- Macro FETCH_BYPASS_EN.
- Defined: when count == 0, not stalled and no branch, the ROM outputs are driven straight onto ir0/ir1/pc_out with ir_valid = 2 in the fetch cycle.
  - Instructions popped via bypass are not written to the queue; the rest are queued.
  - Branch latency becomes t+1 and reset-to-first-valid becomes r+1.
- Undefined: all instructions pass through the queue, with the latencies given above.

Test Plan:
- Program 0..4 = 210A, 220C, 230E, B40E, BC70; reset, dec_ready = 0:
  - Fetch cycle: rom_addr 0, pc_1 0, sel_mem_0 0, sel_mem_1 1.
  - Next cycle: ir_valid 2, ir0 210A, ir1 220C, pc_out 0.
  - Then state FULL with fetch_pc 4; ROM address frozen.
- Queue full, dec_ready = 2 continuously:
  - Pairs (210A, 220C), (230E, B40E), (BC70, 0000) in consecutive cycles; pc_out 0, 2, 4.
- branch_target = 1:
  - Next cycle: rom_addr 0, pc_1 1, sel_mem_0 2, sel_mem_1 0; ir_valid 0.
  - Following cycle: ir0 220C, ir1 230E, pc_out 1.
- Queue count 3 (QDEPTH 4), dec_ready 0:
  - Single write of rom_ir_0, fetch_pc +1, count 4, FULL.
  - Then dec_ready 1: ir0 advances by one per cycle.
- stall = 1 for 3 cycles with dec_ready 2: outputs and fetch_pc unchanged. A branch asserted during stall still flushes and redirects.
- rst asserted one cycle after a branch: all outputs at reset values; fetch restarts at 0.
- With FETCH_BYPASS_EN: ir0 210A visible 1 cycle after reset release. Branch to 3 gives ir0 B40E, ir1 BC70 in the cycle after the branch.
